uart_rx: RTL and testbench

- Serial-to-parallel UART receiver. It is the downstream stage of the bus UART transmitter and consumes the serial line that the transmitter drives.
- Frame format: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Recovers each byte by mid-bit sampling at CLKS_PER_BIT clocks per bit.
- Presents the byte to the bus-side consumer with a one-cycle valid strobe. Flags framing errors and break conditions.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Serial-to-parallel UART receiver. Frame is 1 start bit,
//             8 data bits (LSB first), 1 stop bit, no parity. Each bit is
//             recovered by sampling near mid-bit at CLKS_PER_BIT clocks/bit.
//  Ports    : i_Clock        system clock, rising edge
//             i_Rst_n        asynchronous active-low reset
//             i_Rx_Serial    asynchronous serial line, idle high
//             o_Rx_DV        one-cycle strobe, o_Rx_Byte holds a new byte
//             o_Rx_Byte      last correctly received byte
//             o_Rx_Active    high while a frame is being received
//             o_Rx_Frame_Err one-cycle strobe, stop bit sampled low
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int CLKS_PER_BIT = 87   // legal range 4..255
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Rx_Frame_Err
);

   localparam logic [7:0] C_BIT_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [7:0] C_BIT_HALF = 8'((CLKS_PER_BIT - 1) / 2);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_CLEANUP = 3'd4;
   localparam logic [2:0] ST_BREAK   = 3'd5;

   logic       meta_q, rx_s_q;
   logic [2:0] state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] byte_q, byte_d;
   logic       dv_q, dv_d;
   logic       fe_q, fe_d;
   logic       active_q, active_d;

   // Two-flop synchroniser; both flops reset to the idle (high) line level
   // so that release from reset never looks like a start edge.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         meta_q <= i_Rx_Serial;
         rx_s_q <= meta_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      active_d = active_q;
      dv_d     = 1'b0;
      fe_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            count_d  = 8'd0;
            idx_d    = 3'd0;
            active_d = 1'b0;
            if (!rx_s_q) state_d = ST_START;
         end

         // Re-check the start bit at its middle; a high level there is a glitch.
         ST_START: begin
            if (count_q == C_BIT_HALF) begin
               count_d = 8'd0;
               if (!rx_s_q) begin
                  state_d  = ST_DATA;
                  active_d = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               count_d = count_q + 8'd1;
            end
         end

         // Counting from the start-bit midpoint, a full bit period later lands
         // in the middle of each data bit.
         ST_DATA: begin
            if (count_q == C_BIT_LAST) begin
               count_d         = 8'd0;
               shift_d[idx_q]  = rx_s_q;
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = ST_STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               count_d = count_q + 8'd1;
            end
         end

         ST_STOP: begin
            if (count_q == C_BIT_LAST) begin
               count_d  = 8'd0;
               active_d = 1'b0;
               if (rx_s_q) begin
                  byte_d  = shift_q;
                  dv_d    = 1'b1;
                  state_d = ST_CLEANUP;
               end else begin
                  fe_d    = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               count_d = count_q + 8'd1;
            end
         end

         ST_CLEANUP: begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
         end

         // Wait for the line to return high so a held-low line is not
         // mistaken for a stream of start bits.
         ST_BREAK: begin
            active_d = 1'b0;
            if (rx_s_q) state_d = ST_IDLE;
         end

         default: begin
            state_d  = ST_IDLE;
            count_d  = 8'd0;
            idx_d    = 3'd0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= 8'd0;
         idx_q    <= 3'd0;
         shift_q  <= 8'd0;
         byte_q   <= 8'd0;
         dv_q     <= 1'b0;
         fe_q     <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         fe_q     <= fe_d;
         active_q <= active_d;
      end
   end

   assign o_Rx_DV        = dv_q;
   assign o_Rx_Byte      = byte_q;
   assign o_Rx_Active    = active_q;
   assign o_Rx_Frame_Err = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Three receivers (16, 4 and
//             255 clocks per bit) share clock and reset; one at a time is
//             fed the serial stimulus. A frame-level model predicts the strobe
//             cycle, byte and active window of every frame sent.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic line  = 1'b1;
   int   sel   = 0;          // 0: C=16, 1: C=4, 2: C=255
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   chk_en   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rx16, rx4, rx255;
   logic       dv16, dv4, dv255, fe16, fe4, fe255, ac16, ac4, ac255;
   logic [7:0] by16, by4, by255;

   assign rx16  = (sel == 0) ? line : 1'b1;
   assign rx4   = (sel == 1) ? line : 1'b1;
   assign rx255 = (sel == 2) ? line : 1'b1;

   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx16),
      .o_Rx_DV(dv16), .o_Rx_Byte(by16), .o_Rx_Active(ac16), .o_Rx_Frame_Err(fe16));
   uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx4),
      .o_Rx_DV(dv4), .o_Rx_Byte(by4), .o_Rx_Active(ac4), .o_Rx_Frame_Err(fe4));
   uart_rx #(.CLKS_PER_BIT(255)) u_dut255 (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx255),
      .o_Rx_DV(dv255), .o_Rx_Byte(by255), .o_Rx_Active(ac255), .o_Rx_Frame_Err(fe255));

   logic       w_dv, w_fe, w_ac;
   logic [7:0] w_by;
   assign w_dv = (sel == 0) ? dv16 : (sel == 1) ? dv4 : dv255;
   assign w_fe = (sel == 0) ? fe16 : (sel == 1) ? fe4 : fe255;
   assign w_ac = (sel == 0) ? ac16 : (sel == 1) ? ac4 : ac255;
   assign w_by = (sel == 0) ? by16 : (sel == 1) ? by4 : by255;

   int cbit;
   assign cbit = (sel == 0) ? 16 : (sel == 1) ? 4 : 255;

   // ---- frame-level model state ----
   int         evq_cyc[$];
   bit         evq_err[$];
   logic [7:0] evq_byte[$];
   int         win_lo[$];
   int         win_hi[$];
   logic [7:0] exp_byte = 8'h00;
   int         dv_log_cyc[$];
   logic [7:0] dv_log_byte[$];
   int         fe_cnt = 0;
   int         fe_last_cyc = 0;
   int         last_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison of the selected receiver against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit edv, efe, eact;
         edv = 1'b0;
         efe = 1'b0;
         if (evq_cyc.size() > 0 && evq_cyc[0] == cyc) begin
            edv = !evq_err[0];
            efe = evq_err[0];
            if (edv) exp_byte = evq_byte[0];
            void'(evq_cyc.pop_front());
            void'(evq_err.pop_front());
            void'(evq_byte.pop_front());
         end
         eact = (win_lo.size() > 0) && (cyc >= win_lo[0]) && (cyc <= win_hi[0]);
         if (win_hi.size() > 0 && cyc >= win_hi[0]) begin
            void'(win_lo.pop_front());
            void'(win_hi.pop_front());
         end
         chk("rx_dv",     {31'd0, w_dv}, {31'd0, edv});
         chk("frame_err", {31'd0, w_fe}, {31'd0, efe});
         chk("rx_active", {31'd0, w_ac}, {31'd0, eact});
         chk("rx_byte",   {24'd0, w_by}, {24'd0, exp_byte});
         if (w_dv) begin
            dv_log_cyc.push_back(cyc);
            dv_log_byte.push_back(w_by);
         end
         if (w_fe) begin
            fe_cnt++;
            fe_last_cyc = cyc;
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic drive_bit(input logic v);
      line = v;
      repeat (cbit) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      line = 1'b1;
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Line driven in cycle n reaches the receiver's FSM in cycle n+2; the
   // strobe follows H + 9C + 2 cycles later.
   task automatic expect_frame(input logic [7:0] b, input bit err);
      int h;
      h = (cbit - 1) / 2;
      last_n = cyc;
      evq_cyc.push_back(cyc + h + 9 * cbit + 4);
      evq_err.push_back(err);
      evq_byte.push_back(b);
      win_lo.push_back(cyc + h + 4);
      win_hi.push_back(cyc + h + 9 * cbit + 3);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      expect_frame(b, !stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_v);
   endtask

   task automatic clear_logs();
      dv_log_cyc.delete();
      dv_log_byte.delete();
      fe_cnt = 0;
   endtask

   task automatic flush_model();
      evq_cyc.delete();
      evq_err.delete();
      evq_byte.delete();
      win_lo.delete();
      win_hi.delete();
      exp_byte = 8'h00;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b2 [3];
      b2[0] = 8'h00; b2[1] = 8'hFF; b2[2] = 8'h3C;

      #2 rst_n = 1'b0;
      #1;
      chk("reset_dv",     {31'd0, dv16}, 32'd0);
      chk("reset_byte",   {24'd0, by16}, 32'd0);
      chk("reset_active", {31'd0, ac16}, 32'd0);
      chk("reset_fe",     {31'd0, fe16}, 32'd0);
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      idle(10);

      // 1: clean 0xA5
      clear_logs();
      send_frame(8'hA5, 1'b1);
      idle(20);
      chk("t1_dv_count", dv_log_cyc.size(), 32'd1);
      if (dv_log_cyc.size() == 1) begin
         chk("t1_dv_latency", dv_log_cyc[0] - last_n, 32'd155);
         chk("t1_dv_byte", {24'd0, dv_log_byte[0]}, 32'hA5);
      end
      chk("t1_fe_count", fe_cnt, 32'd0);

      // 2: back-to-back frames
      clear_logs();
      for (int i = 0; i < 3; i++) send_frame(b2[i], 1'b1);
      idle(20);
      chk("t2_dv_count", dv_log_cyc.size(), 32'd3);
      if (dv_log_cyc.size() == 3) begin
         for (int i = 0; i < 3; i++)
            chk("t2_dv_byte", {24'd0, dv_log_byte[i]}, {24'd0, b2[i]});
         chk("t2_gap01", dv_log_cyc[1] - dv_log_cyc[0], 32'd160);
         chk("t2_gap12", dv_log_cyc[2] - dv_log_cyc[1], 32'd160);
      end

      // 3: 4-cycle glitch, then 0x5A
      clear_logs();
      line = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(30);
      chk("t3_glitch_dv", dv_log_cyc.size(), 32'd0);
      chk("t3_glitch_fe", fe_cnt, 32'd0);
      send_frame(8'h5A, 1'b1);
      idle(20);
      chk("t3_byte", {24'd0, w_by}, 32'h5A);

      // 4: framing error followed by a long break
      clear_logs();
      send_frame(8'h81, 1'b0);
      line = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("t4_fe_count", fe_cnt, 32'd1);
      chk("t4_fe_latency", fe_last_cyc - last_n, 32'd155);
      chk("t4_dv_count", dv_log_cyc.size(), 32'd0);
      chk("t4_byte_held", {24'd0, w_by}, 32'h5A);
      idle(40);
      chk("t4_fe_after", fe_cnt, 32'd1);
      send_frame(8'h42, 1'b1);
      idle(20);
      chk("t4_next_byte", {24'd0, w_by}, 32'h42);

      // 5: async reset during data bit 4 of 0xC3
      clear_logs();
      expect_frame(8'hC3, 1'b0);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
      line = 1'b0;               // bit 4 of 0xC3
      repeat (8) @(posedge clk);
      #3;
      chk("t5_active_before", {31'd0, w_ac}, 32'd1);
      rst_n = 1'b0;
      flush_model();
      #1;
      chk("t5_rst_dv",     {31'd0, w_dv}, 32'd0);
      chk("t5_rst_byte",   {24'd0, w_by}, 32'd0);
      chk("t5_rst_active", {31'd0, w_ac}, 32'd0);
      chk("t5_rst_fe",     {31'd0, w_fe}, 32'd0);
      line = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      idle(20);
      chk("t5_no_dv", dv_log_cyc.size(), 32'd0);
      send_frame(8'h99, 1'b1);
      idle(20);
      chk("t5_byte", {24'd0, w_by}, 32'h99);

      // 6: extreme bit periods
      sel = 1;
      exp_byte = 8'h00;
      idle(10);
      clear_logs();
      send_frame(8'h6B, 1'b1);
      idle(20);
      chk("t6a_dv_count", dv_log_cyc.size(), 32'd1);
      if (dv_log_cyc.size() == 1)
         chk("t6a_latency", dv_log_cyc[0] - last_n, 32'd41);
      chk("t6a_byte", {24'd0, w_by}, 32'h6B);

      sel = 2;
      exp_byte = 8'h00;
      idle(10);
      clear_logs();
      send_frame(8'h6B, 1'b1);
      idle(20);
      chk("t6b_dv_count", dv_log_cyc.size(), 32'd1);
      if (dv_log_cyc.size() == 1)
         chk("t6b_latency", dv_log_cyc[0] - last_n, 32'd2426);
      chk("t6b_byte", {24'd0, w_by}, 32'h6B);

      chk("pending_events", evq_cyc.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
